spi_slave: RTL

- SPI peripheral (responder) end of the team's SPI link: mode 0 (SCLK idle low), LSB first, 8-bit bytes, active-low SSn.
- Oversamples SCLK, SSn and MOSI on the system clock, shifts the received byte in from MOSI, and drives MISO from a one-byte transmit holding buffer.
- Receive and transmit handshakes towards local logic match the master's txgo/txrdy/rxdout style.
- A frame may carry several back-to-back bytes while SSn stays low.

---
 rtl/spi_slave_if.sv | 25 ++
 rtl/spi_slave.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// SPI responder bundle: the serial pins plus the local tx/rx handshakes.
`timescale 1ns/1ps
interface spi_slave_if;
    logic       SCLK;
    logic       SSn;
    logic       MOSI;
    logic       MISO;
    logic [7:0] txdin;
    logic       txgo;
    logic       txrdy;
    logic [7:0] rxdout;
    logic       rxnew;
    logic       rxabort;
    logic       txunder;

    modport slave (
        input  SCLK, SSn, MOSI, txdin, txgo,
        output MISO, txrdy, rxdout, rxnew, rxabort, txunder
    );

    modport master (
        output SCLK, SSn, MOSI, txdin, txgo,
        input  MISO, txrdy, rxdout, rxnew, rxabort, txunder
    );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 responder, LSB first, 8-bit bytes; oversamples the serial pins
// on clk and serves MISO from a one-byte transmit holding buffer.
`timescale 1ns/1ps
module spi_slave #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_MISO   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    spi_slave_if.slave  bus
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    // bit 0 = SCLK, bit 1 = SSn, bit 2 = MOSI
    localparam logic [2:0] SYNC_INIT = 3'b010;

    logic [2:0] raw_in;
    logic [2:0] sync_s;
    logic [1:0] hist_reg;

    assign raw_in = {bus.MOSI, bus.SSn, bus.SCLK};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) chain_reg <= {SYNC_STAGES{SYNC_INIT[gi]}};
                else      chain_reg <= {chain_reg[SYNC_STAGES-2:0], raw_in[gi]};
            end
            assign sync_s[gi] = chain_reg[SYNC_STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) hist_reg <= SYNC_INIT[1:0];
        else      hist_reg <= sync_s[1:0];
    end

    logic sclk_rise, sclk_fall, ssn_fall, ssn_rise, mosi_s;
    assign sclk_rise = sync_s[0] & ~hist_reg[0];
    assign sclk_fall = ~sync_s[0] & hist_reg[0];
    assign ssn_fall  = ~sync_s[1] & hist_reg[1];
    assign ssn_rise  = sync_s[1] & ~hist_reg[1];
    assign mosi_s    = sync_s[2];

    state_t     state_reg, state_next;
    logic [2:0] bitcnt_reg, bitcnt_next;
    logic [7:0] rx_shift_reg, rx_shift_next;
    logic [7:0] tx_shift_reg, tx_shift_next;
    logic [7:0] buf_reg, buf_next;
    logic       txrdy_reg, txrdy_next;
    logic       miso_reg, miso_next;
    logic       miso_load_reg, miso_load_next;
    logic [7:0] rxdout_reg, rxdout_next;
    logic       rxnew_reg, rxnew_next;
    logic       rxabort_reg, rxabort_next;
    logic       txunder_reg, txunder_next;
    logic       slot_load;
    logic [7:0] rx_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            bitcnt_reg    <= '0;
            rx_shift_reg  <= '0;
            tx_shift_reg  <= '0;
            buf_reg       <= '0;
            txrdy_reg     <= 1'b1;
            miso_reg      <= IDLE_MISO;
            miso_load_reg <= 1'b0;
            rxdout_reg    <= '0;
            rxnew_reg     <= 1'b0;
            rxabort_reg   <= 1'b0;
            txunder_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            bitcnt_reg    <= bitcnt_next;
            rx_shift_reg  <= rx_shift_next;
            tx_shift_reg  <= tx_shift_next;
            buf_reg       <= buf_next;
            txrdy_reg     <= txrdy_next;
            miso_reg      <= miso_next;
            miso_load_reg <= miso_load_next;
            rxdout_reg    <= rxdout_next;
            rxnew_reg     <= rxnew_next;
            rxabort_reg   <= rxabort_next;
            txunder_reg   <= txunder_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bitcnt_next    = bitcnt_reg;
        rx_shift_next  = rx_shift_reg;
        tx_shift_next  = tx_shift_reg;
        buf_next       = buf_reg;
        txrdy_next     = txrdy_reg;
        miso_next      = miso_reg;
        miso_load_next = 1'b0;
        rxdout_next    = rxdout_reg;
        rxnew_next     = 1'b0;
        rxabort_next   = 1'b0;
        txunder_next   = 1'b0;
        slot_load      = 1'b0;
        rx_word        = {mosi_s, rx_shift_reg[7:1]};

        case (state_reg)
            IDLE: begin
                miso_next = IDLE_MISO;
                if (ssn_fall) begin
                    state_next  = ACTIVE;
                    bitcnt_next = '0;
                    slot_load   = 1'b1;
                end
            end
            ACTIVE: begin
                // Deselect outranks any SCLK edge seen in the same cycle.
                if (ssn_rise) begin
                    state_next    = IDLE;
                    miso_next     = IDLE_MISO;
                    bitcnt_next   = '0;
                    rx_shift_next = '0;
                    rxabort_next  = (bitcnt_reg != 3'd0);
                end else begin
                    if (miso_load_reg) miso_next = tx_shift_reg[0];
                    if (sclk_rise) begin
                        rx_shift_next = rx_word;
                        if (bitcnt_reg == 3'd7) begin
                            bitcnt_next = '0;
                            rxdout_next = rx_word;
                            rxnew_next  = 1'b1;
                            slot_load   = 1'b1;
                        end else begin
                            bitcnt_next = bitcnt_reg + 3'd1;
                        end
                    end else if (sclk_fall && bitcnt_reg != 3'd0) begin
                        // No shift at bitcnt 0: a just-loaded byte keeps its bit 0.
                        tx_shift_next = {IDLE_MISO, tx_shift_reg[7:1]};
                        miso_next     = tx_shift_reg[1];
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (slot_load) begin
            miso_load_next = 1'b1;
            if (!txrdy_reg) begin
                tx_shift_next = buf_reg;
                txrdy_next    = 1'b1;
            end else begin
                tx_shift_next = {8{IDLE_MISO}};
                txunder_next  = 1'b1;
            end
        end

        // Uses the registered txrdy, so a load in this cycle takes the old buffer.
        if (bus.txgo && txrdy_reg) begin
            buf_next   = bus.txdin;
            txrdy_next = 1'b0;
        end
    end

    assign bus.MISO    = miso_reg;
    assign bus.txrdy   = txrdy_reg;
    assign bus.rxdout  = rxdout_reg;
    assign bus.rxnew   = rxnew_reg;
    assign bus.rxabort = rxabort_reg;
    assign bus.txunder = txunder_reg;
endmodule
